send_arbiter: RTL
=================

Name: send_arbiter

Overview:
- Shares the single outbound path between NREQ message producers: the send ring (byte data) and the send length FIFO (one entry per message).
- Producers are command responses, involuntary unit reports (endstop, gpio poll, uart) and system messages.
- Grants one producer at a time, round-robin, and holds the grant for a whole message.
- Streams the message bytes into the ring, counts them, and commits the length to the FIFO when the producer flags the last byte.

Parameters:
- NREQ, 4, number of requesting producers (2..8)
- LEN_BITS, 8, width of the length word written to the length FIFO
- PTR_BITS, $clog2(NREQ), width of the grant index

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NREQ  per-producer byte valid; first assertion is the message request
- req_data  in  8*NREQ  per-producer byte; producer i drives bits [8i+7:8i]
- req_last  in  NREQ  per-producer flag: the current byte ends the message
- req_ready  out  NREQ  per-producer byte accepted this cycle (combinational)
- send_ring_data  out  8  byte to the ring (combinational mux)
- send_ring_wr_en  out  1  ring write strobe (combinational)
- send_ring_full  in  1  ring cannot take a byte this cycle
- send_fifo_data  out  LEN_BITS  message length (registered)
- send_fifo_wr_en  out  1  length FIFO write strobe (registered, one cycle)
- send_fifo_full  in  1  length FIFO cannot take an entry
- busy  out  1  state != IDLE
- grant_idx  out  PTR_BITS  index of the current owner; valid while busy
- overflow  out  1  sticky: a message was force-terminated; cleared only by rst

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, len=0, overflow=0, send_fifo_wr_en=0, send_fifo_data=0, grant_idx=0. req_ready=0 and send_ring_wr_en=0 follow combinationally.
- States: IDLE, XFER, COMMIT.
- IDLE, arbitration:
  - If any req_valid bit is set, pick the first set index scanning from rr_ptr upward, modulo NREQ.
  - Register that index as grant_idx, clear len, go to XFER. No byte is accepted in the arbitration cycle.
- XFER, byte acceptance:
  - accept = req_valid[grant_idx] && !send_ring_full.
  - On accept: req_ready[grant_idx]=1, send_ring_wr_en=1 and send_ring_data=req_data[grant_idx] in the same cycle, len<=len+1.
  - All other req_ready bits stay 0.
  - If req_valid drops mid-message, stall with no timeout.
- XFER, end of message:
  - accept && req_last: go to COMMIT; the final length includes this byte.
  - accept with len == 2^LEN_BITS-2 and no req_last: treat the byte as last, set overflow, go to COMMIT.
  - Consequence: the committed length never exceeds 2^LEN_BITS-1 and never wraps.
- COMMIT:
  - No bytes are accepted.
  - If !send_fifo_full: register send_fifo_wr_en=1 and send_fifo_data=len, set rr_ptr <= (grant_idx+1) mod NREQ, go to IDLE.
  - Otherwise hold in COMMIT.
- send_fifo_wr_en is a single-cycle pulse and self-clears the next cycle.
- Latency:
  - From a request seen in IDLE, the first byte can be accepted 1 cycle later.
  - From the last byte, the length write is registered 1 cycle later; the earliest next grant is 1 cycle after that.
- A fully idle ring is one byte per cycle inside a message.
- Simultaneous requests: only the round-robin winner proceeds; losers keep req_valid and data stable until served.
- A zero-length message is impossible: every message carries at least one byte.
- Reset mid-message: bytes already written to the ring are not retracted. The ring and FIFO owners share rst, so both are flushed together.

Test Plan:
- Single message: producer 1 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), ring/FIFO never full -> ring writes in 3 consecutive cycles starting 1 cycle after req_valid; one FIFO write len=3; rr_ptr=2.
- Fairness: producers 0 and 2 both request 2-byte messages continuously from reset -> grant order 0,2,0,2; messages never interleave; every FIFO entry=2.
- Ring backpressure: send_ring_full high for 4 cycles in the middle of a 5-byte message -> no req_ready/wr_en while full; byte order preserved; FIFO len=5.
- FIFO backpressure: send_fifo_full high when the last byte is accepted, released 3 cycles later -> state holds COMMIT; a single FIFO write len after release; no new grant until then.
- Overflow (LEN_BITS=4): producer streams 20 bytes without req_last -> commit after byte 15 with len=15; overflow=1 and stays set; the remaining 5 bytes form a new message after re-arbitration.
- Reset mid-message: assert rst after 2 of 4 bytes -> outputs go to reset values immediately; rr_ptr=0; no FIFO write occurs.

Source files
------------

// File: rtl/send_arbiter_if.sv
// Outbound message path bundle: producer handshakes, ring/FIFO write side and status.
interface send_arbiter_if #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LEN_BITS = 8,
  parameter int unsigned PTR_BITS = $clog2(NREQ)
);
  logic [NREQ-1:0]     req_valid;
  logic [8*NREQ-1:0]   req_data;
  logic [NREQ-1:0]     req_last;
  logic [NREQ-1:0]     req_ready;
  logic [7:0]          send_ring_data;
  logic                send_ring_wr_en;
  logic                send_ring_full;
  logic [LEN_BITS-1:0] send_fifo_data;
  logic                send_fifo_wr_en;
  logic                send_fifo_full;
  logic                busy;
  logic [PTR_BITS-1:0] grant_idx;
  logic                overflow;

  // Producers plus ring/FIFO environment
  modport master (
    output req_valid, req_data, req_last, send_ring_full, send_fifo_full,
    input  req_ready, send_ring_data, send_ring_wr_en, send_fifo_data, send_fifo_wr_en,
    input  busy, grant_idx, overflow
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_last, send_ring_full, send_fifo_full,
    output req_ready, send_ring_data, send_ring_wr_en, send_fifo_data, send_fifo_wr_en,
    output busy, grant_idx, overflow
  );
endinterface

// File: rtl/send_arbiter.sv
// Round-robin arbiter feeding the send ring (bytes) and send length FIFO (one entry per
// message). A grant is held for a whole message; the length is committed after the last byte.
module send_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned LEN_BITS = 8,
  parameter int unsigned PTR_BITS = $clog2(NREQ)
) (
  input logic          clk,
  input logic          rst,
  send_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StXfer, StCommit} state_e;

  // One below all-ones: accepting a byte at this count forces the end of the message
  localparam logic [LEN_BITS-1:0] LenSat = {{(LEN_BITS-1){1'b1}}, 1'b0};

  state_e              state_q, state_d;
  logic [PTR_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_BITS-1:0] grant_q, grant_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic                overflow_q, overflow_d;
  logic                fifo_wr_q, fifo_wr_d;
  logic [LEN_BITS-1:0] fifo_data_q, fifo_data_d;

  logic                found;
  logic [PTR_BITS-1:0] win;
  logic [PTR_BITS-1:0] cand;
  logic [7:0]          sel_data;
  logic                sel_last;
  logic                accept;
  logic [NREQ-1:0]     req_ready;
  logic                ring_wr_en;

  // Round-robin search: first requester at or above rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = PTR_BITS'((32'(rr_ptr_q) + i) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Byte/last mux from the current owner
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (PTR_BITS'(i) == grant_q) begin
        sel_data = bus.req_data[8*i +: 8];
        sel_last = bus.req_last[i];
      end
    end
  end

  // Next-state and handshake logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    len_d       = len_q;
    overflow_d  = overflow_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    accept      = 1'b0;
    req_ready   = '0;
    ring_wr_en  = 1'b0;
    case (state_q)
      StIdle: begin
        // Arbitration cycle never accepts a byte
        if (found) begin
          grant_d = win;
          len_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        accept = bus.req_valid[grant_q] && !bus.send_ring_full;
        if (accept) begin
          req_ready  = NREQ'(1) << grant_q;
          ring_wr_en = 1'b1;
          len_d      = len_q + 1'b1;
          if (sel_last) begin
            state_d = StCommit;
          end else if (len_q == LenSat) begin
            overflow_d = 1'b1;
            state_d    = StCommit;
          end
        end
      end
      StCommit: begin
        if (!bus.send_fifo_full) begin
          fifo_wr_d   = 1'b1;
          fifo_data_d = len_q;
          rr_ptr_d    = (grant_q == PTR_BITS'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, async active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      len_q       <= '0;
      overflow_q  <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      len_q       <= len_d;
      overflow_q  <= overflow_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.send_ring_data  = sel_data;
  assign bus.send_ring_wr_en = ring_wr_en;
  assign bus.send_fifo_data  = fifo_data_q;
  assign bus.send_fifo_wr_en = fifo_wr_q;
  assign bus.busy            = (state_q != StIdle);
  assign bus.grant_idx       = grant_q;
  assign bus.overflow        = overflow_q;

endmodule
